// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_pkg
//  Description : Shared constants and FSM state encoding for instruction fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

    localparam logic [31:0] c_RESET_VECTOR = 32'h0100_0000;
    localparam logic [31:0] c_INSTR_BYTES  = 32'd4;

    localparam int          c_STATE_W      = 2;
    localparam logic [1:0]  c_ST_IDLE      = 2'd0;
    localparam logic [1:0]  c_ST_WAIT      = 2'd1;
    localparam logic [1:0]  c_ST_HOLD      = 2'd2;
    localparam logic [1:0]  c_ST_FAULT     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Single-outstanding instruction fetch FSM with redirect/squash.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = c_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        pc_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    output logic [31:0] ir_data,
    output logic [31:0] ir_pc,
    input  logic        ir_ready,
    output logic        fetch_fault
);

    logic [c_STATE_W-1:0] r_state;
    logic                 r_req;
    logic [31:0]          r_addr;
    logic                 r_ir_valid;
    logic [31:0]          r_ir_data;
    logic [31:0]          r_ir_pc;
    logic                 r_squash;
    logic                 r_fault;

    logic [c_STATE_W-1:0] w_state_nxt;
    logic                 w_req_nxt;
    logic [31:0]          w_addr_nxt;
    logic                 w_ir_valid_nxt;
    logic [31:0]          w_ir_data_nxt;
    logic [31:0]          w_ir_pc_nxt;
    logic                 w_squash_nxt;
    logic                 w_fault_nxt;
    logic                 w_pc_en;
    logic [31:0]          w_pc_next;
    logic                 w_misaligned;

    assign w_misaligned = |pc_in[1:0];

    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_addr_nxt     = r_addr;
        w_ir_valid_nxt = r_ir_valid;
        w_ir_data_nxt  = r_ir_data;
        w_ir_pc_nxt    = r_ir_pc;
        w_squash_nxt   = r_squash;
        w_fault_nxt    = r_fault;
        w_pc_en        = 1'b0;
        w_pc_next      = pc_in;

        // PC update priority: reset, then redirect, then a live (unsquashed) ack
        if (rst) begin
            w_pc_en   = 1'b1;
            w_pc_next = RESET_VECTOR;
        end else if (redirect_valid) begin
            w_pc_en   = 1'b1;
            w_pc_next = redirect_pc;
        end else if ((r_state == c_ST_WAIT) && imem_ack && !r_squash) begin
            w_pc_en   = 1'b1;
            w_pc_next = r_addr + c_INSTR_BYTES;
        end

        case (r_state)
            c_ST_IDLE: begin
                if (!redirect_valid) begin
                    if (w_misaligned) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = c_ST_FAULT;
                    end else begin
                        w_addr_nxt  = pc_in;
                        w_req_nxt   = 1'b1;
                        w_state_nxt = c_ST_WAIT;
                    end
                end
            end
            c_ST_WAIT: begin
                if (imem_ack) begin
                    w_req_nxt = 1'b0;
                    if (redirect_valid || r_squash) begin
                        w_squash_nxt = 1'b0;
                        w_state_nxt  = c_ST_IDLE;
                    end else begin
                        w_ir_data_nxt  = imem_rdata;
                        w_ir_pc_nxt    = r_addr;
                        w_ir_valid_nxt = 1'b1;
                        w_state_nxt    = c_ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    // Request already on the bus; let it complete and drop its data
                    w_squash_nxt = 1'b1;
                end
            end
            c_ST_HOLD: begin
                if (redirect_valid || ir_ready) begin
                    w_ir_valid_nxt = 1'b0;
                    w_state_nxt    = c_ST_IDLE;
                end
            end
            c_ST_FAULT: begin
                if (redirect_valid) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        if (redirect_valid) begin
            w_ir_valid_nxt = 1'b0;
            w_fault_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_req      <= 1'b0;
            r_addr     <= 32'h0;
            r_ir_valid <= 1'b0;
            r_ir_data  <= 32'h0;
            r_ir_pc    <= 32'h0;
            r_squash   <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            r_addr     <= w_addr_nxt;
            r_ir_valid <= w_ir_valid_nxt;
            r_ir_data  <= w_ir_data_nxt;
            r_ir_pc    <= w_ir_pc_nxt;
            r_squash   <= w_squash_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    assign pc_en       = w_pc_en;
    assign pc_next     = w_pc_next;
    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign ir_valid    = r_ir_valid;
    assign ir_data     = r_ir_data;
    assign ir_pc       = r_ir_pc;
    assign fetch_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Scoreboard bench for instruction_fetch with a PC and memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam logic [31:0] c_RV = 32'h0100_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic [31:0] ir_data;
    logic [31:0] ir_pc;
    logic        ir_ready;
    logic        fetch_fault;

    int   checks = 0;
    int   errors = 0;
    int   n_xfer = 0;
    bit   rand_phase = 1'b0;
    exp_t exp_q[$];

    instruction_fetch #(.RESET_VECTOR(c_RV)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_reg),
        .pc_next        (pc_next),
        .pc_en          (pc_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .ir_valid       (ir_valid),
        .ir_data        (ir_data),
        .ir_pc          (ir_pc),
        .ir_ready       (ir_ready),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    // Program counter register living outside the fetch unit
    always @(posedge clk) begin
        if (pc_en) pc_reg <= pc_next;
    end

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: transfers popped against the expected sequential stream
    logic        prev_req, prev_ack;
    logic [31:0] prev_addr;
    always @(negedge clk) begin
        if (rand_phase && !rst) begin
            if (ir_valid && ir_ready && !redirect_valid) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_instr_pc", ir_pc, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("xfer_pc", ir_pc, e.pc);
                    chk("xfer_data", ir_data, e.data);
                end
            end
            if (prev_req && !prev_ack) begin
                chk("req_held", {31'b0, imem_req}, 32'd1);
                chk("addr_held", imem_addr, prev_addr);
            end
            if (fetch_fault) chk("fault_no_req", {31'b0, imem_req}, 32'd0);
        end
        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
    end

    int          mcnt = -1;
    logic [31:0] maddr;
    int          since_redir;
    int          mis_wait;

    task automatic do_redirect(input logic [31:0] tgt);
        exp_t e;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        exp_q.delete();
        if (tgt[1:0] == 2'b00) begin
            for (int i = 0; i < 64; i++) begin
                e.pc   = tgt + 32'(4 * i);
                e.data = mem_fn(e.pc);
                exp_q.push_back(e);
            end
            mis_wait = 0;
        end else begin
            mis_wait = 12;
        end
        since_redir = 0;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(0, 7))
            0:       t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
            1:       t = {$urandom} | 32'($urandom_range(1, 3));
            default: t = {$urandom} & 32'hFFFF_FFFC;
        endcase
        return t;
    endfunction

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; ir_ready = 1'b0; pc_reg = 32'h0;
        tick(); tick();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
        chk("rst_pc_en", {31'b0, pc_en}, 32'd1);
        chk("rst_pc_next", pc_next, c_RV);

        // First fetch, ack two cycles after the request
        rst = 1'b0;
        tick();
        chk("f1_addr", imem_addr, c_RV);
        chk("f1_req", {31'b0, imem_req}, 32'd1);
        tick();
        chk("f1_wait_req", {31'b0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093; #1;
        chk("f1_pc_en", {31'b0, pc_en}, 32'd1);
        chk("f1_pc_next", pc_next, 32'h0100_0004);
        tick(); imem_ack = 1'b0;
        chk("f1_ir_valid", {31'b0, ir_valid}, 32'd1);
        chk("f1_ir_pc", ir_pc, c_RV);
        chk("f1_ir_data", ir_data, 32'h0050_0093);
        chk("f1_pc_reg", pc_reg, 32'h0100_0004);

        // Decode stalls for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", {31'b0, ir_valid}, 32'd1);
            chk("hold_data", ir_data, 32'h0050_0093);
            chk("hold_pc", ir_pc, c_RV);
            chk("hold_no_req", {31'b0, imem_req}, 32'd0);
        end
        ir_ready = 1'b1;
        tick(); ir_ready = 1'b0;
        chk("xfer_valid_clr", {31'b0, ir_valid}, 32'd0);
        tick();
        chk("f2_addr", imem_addr, 32'h0100_0004);

        // Redirect one cycle before the ack
        redirect_valid = 1'b1; redirect_pc = 32'h0100_0100; #1;
        chk("sq_pc_next", pc_next, 32'h0100_0100);
        tick(); redirect_valid = 1'b0;
        chk("sq_req_kept", {31'b0, imem_req}, 32'd1);
        chk("sq_addr_kept", imem_addr, 32'h0100_0004);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
        chk("sq_no_pc_en", {31'b0, pc_en}, 32'd0);
        tick(); imem_ack = 1'b0;
        chk("sq_ir_valid", {31'b0, ir_valid}, 32'd0);
        tick();
        chk("sq_new_addr", imem_addr, 32'h0100_0100);
        chk("sq_ir_valid2", {31'b0, ir_valid}, 32'd0);

        // Redirect coincident with ack
        tick();
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        redirect_valid = 1'b1; redirect_pc = 32'h0100_0200; #1;
        chk("co_pc_next", pc_next, 32'h0100_0200);
        tick(); imem_ack = 1'b0; redirect_valid = 1'b0;
        chk("co_ir_valid", {31'b0, ir_valid}, 32'd0);
        tick();
        chk("co_addr", imem_addr, 32'h0100_0200);

        // Misaligned PC via redirect from HOLD
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        tick(); imem_ack = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0100_0002;
        tick(); redirect_valid = 1'b0;
        chk("mis_drop", {31'b0, ir_valid}, 32'd0);
        tick();
        chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
        chk("mis_no_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("mis_fault_held", {31'b0, fetch_fault}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0100_0008;
        tick(); redirect_valid = 1'b0;
        chk("mis_fault_clr", {31'b0, fetch_fault}, 32'd0);
        tick();
        chk("mis_refetch", imem_addr, 32'h0100_0008);
        chk("mis_refetch_req", {31'b0, imem_req}, 32'd1);

        // Top-of-address-space wrap
        imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
        tick(); imem_ack = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(); redirect_valid = 1'b0;
        tick();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = 32'h2222_2222; #1;
        chk("wrap_pc_next", pc_next, 32'h0);
        tick(); imem_ack = 1'b0;
        chk("wrap_ir_pc", ir_pc, 32'hFFFF_FFFC);
        chk("wrap_no_fault", {31'b0, fetch_fault}, 32'd0);
        ir_ready = 1'b1;
        tick(); ir_ready = 1'b0;
        tick();
        chk("wrap_next_addr", imem_addr, 32'h0);
        chk("wrap_next_fault", {31'b0, fetch_fault}, 32'd0);

        // Reset mid-WAIT, then a late ack in IDLE
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0123; #1;
        chk("rst_over_redir", pc_next, c_RV);
        tick(); redirect_valid = 1'b0;
        chk("rst2_req", {31'b0, imem_req}, 32'd0);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h4444_4444; #1;
        chk("late_ack_pc_en", {31'b0, pc_en}, 32'd0);
        tick(); imem_ack = 1'b0;
        chk("late_ack_addr", imem_addr, c_RV);
        tick();
        chk("late_ack_ir_valid", {31'b0, ir_valid}, 32'd0);

        // Randomized phase: auto-responding memory, random ready and redirects
        since_redir = 40;
        mis_wait    = 0;
        rand_phase  = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            redirect_valid = 1'b0;
            imem_ack       = 1'b0;
            since_redir++;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_fn(maddr);
                    mcnt       = -1;
                end
            end else if (imem_req) begin
                maddr = imem_addr;
                mcnt  = $urandom_range(1, 3);
            end
            ir_ready = ($urandom_range(0, 3) != 0);
            if (mis_wait > 0) begin
                if (fetch_fault) begin
                    chk("rnd_fault_no_req", {31'b0, imem_req}, 32'd0);
                    chk("rnd_fault_no_valid", {31'b0, ir_valid}, 32'd0);
                    do_redirect(rand_target() & 32'hFFFF_FFFC);
                end else begin
                    mis_wait--;
                    if (mis_wait == 0) begin
                        chk("rnd_fault_timeout", {31'b0, fetch_fault}, 32'd1);
                        do_redirect(rand_target() & 32'hFFFF_FFFC);
                    end
                end
            end else if (since_redir >= 40 || $urandom_range(0, 11) == 0) begin
                do_redirect(rand_target());
            end
        end
        tick();
        rand_phase = 1'b0;
        chk("rnd_xfer_count_ok", {31'b0, (n_xfer > 100)}, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
